// File: rtl/sample_burst_monitor.sv
// sample_burst_monitor: decodes gated burst sample clock and checks widths, counts and silence
module sample_burst_monitor (
  input  logic        HF_CLK,
  input  logic        NRST_sync,
  input  logic        SAMPLE_CLK_in,
  input  logic        phase_in,
  input  logic [11:0] PHASE1DIV1_sync,
  input  logic [3:0]  PHASE1COUNT_sync,
  input  logic [9:0]  PHASE2COUNT_sync,
  input  logic        ENSAMP_sync,
  input  logic        TEMP_RUN,
  input  logic        CLR_ERR,
  output logic        BURST_DONE,
  output logic [4:0]  PULSE_COUNT,
  output logic [12:0] SIL_LEN,
  output logic [15:0] BURST_TOTAL,
  output logic [4:0]  ERR_FLAGS,
  output logic        ERR
);
  localparam logic [2:0] IDLE = 3'd0, LEAD = 3'd1, HIGH = 3'd2, LOW = 3'd3, SILENCE = 3'd4;
  logic [2:0]  state_q, state_d;
  logic        s_q, p_q;
  logic [12:0] wcnt_q, wcnt_d;
  logic [4:0]  pcnt_q, pcnt_d;
  logic        done_q, done_d;
  logic [4:0]  pc_q, pc_d;
  logic [12:0] sil_q, sil_d;
  logic [15:0] tot_q, tot_d;
  logic [4:0]  flags_q, flags_d, err;
  logic        en, rise, fall, prise, pfall, fin;
  logic [4:0]  exp_n, n;
  logic [12:0] div13, p2_13;
  assign en    = (ENSAMP_sync | TEMP_RUN) && PHASE1DIV1_sync != 12'd0;
  assign rise  = SAMPLE_CLK_in & ~s_q;
  assign fall  = ~SAMPLE_CLK_in & s_q;
  assign prise = phase_in & ~p_q;
  assign pfall = ~phase_in & p_q;
  assign exp_n = PHASE1COUNT_sync != 4'd0 ? {1'b0, PHASE1COUNT_sync} : 5'd16;
  assign n     = pcnt_q + 5'd1;
  assign div13 = {1'b0, PHASE1DIV1_sync};
  assign p2_13 = {3'b0, PHASE2COUNT_sync};
  // Burst decoder: state walk, per-segment checks and completion bookkeeping
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    wcnt_d  = (rise | fall) ? 13'd1 : (&wcnt_q ? wcnt_q : wcnt_q + 13'd1);
    err     = 5'd0;
    fin     = 1'b0;
    if (!en) begin
      state_d = IDLE;
      pcnt_d  = 5'd0;
      wcnt_d  = 13'd0;
    end else begin
      case (state_q)
        IDLE: state_d = LEAD;
        LEAD: if (rise) begin
          state_d = HIGH;
          pcnt_d  = 5'd0;
        end
        HIGH: if (fall) begin
          err[0] = wcnt_q != div13;
          state_d = LOW;
          if (phase_in) begin
            err[2]  = n != exp_n;
            fin     = 1'b1;
            state_d = SILENCE;
          end else if (PHASE2COUNT_sync == 10'd0 && n == exp_n) begin
            fin    = 1'b1;
            pcnt_d = 5'd0;
          end else if (PHASE2COUNT_sync != 10'd0 && n >= exp_n) begin
            err[2] = 1'b1;
            pcnt_d = &pcnt_q ? pcnt_q : n;
          end else pcnt_d = n;
        end else err[4] = prise;
        LOW: begin
          err[4] = prise;
          if (rise) begin
            err[1]  = wcnt_q != div13;
            state_d = HIGH;
          end
        end
        SILENCE: if (rise) begin
          err[3]  = wcnt_q != p2_13;
          err[4]  = phase_in;
          pcnt_d  = 5'd0;
          state_d = HIGH;
        end else if (pfall) begin
          err[4]  = 1'b1;
          state_d = LEAD;
        end
        default: state_d = IDLE;
      endcase
    end
    done_d  = fin;
    pc_d    = fin ? n : pc_q;
    tot_d   = fin && !(&tot_q) ? tot_q + 16'd1 : tot_q;
    sil_d   = en && state_q == SILENCE && rise ? wcnt_q : sil_q;
    flags_d = (CLR_ERR ? 5'd0 : flags_q) | err;
  end
  // State and result registers
  always_ff @(posedge HF_CLK or negedge NRST_sync) begin
    if (!NRST_sync) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      p_q     <= 1'b0;
      wcnt_q  <= 13'd0;
      pcnt_q  <= 5'd0;
      done_q  <= 1'b0;
      pc_q    <= 5'd0;
      sil_q   <= 13'd0;
      tot_q   <= 16'd0;
      flags_q <= 5'd0;
    end else begin
      state_q <= state_d;
      s_q     <= SAMPLE_CLK_in;
      p_q     <= phase_in;
      wcnt_q  <= wcnt_d;
      pcnt_q  <= pcnt_d;
      done_q  <= done_d;
      pc_q    <= pc_d;
      sil_q   <= sil_d;
      tot_q   <= tot_d;
      flags_q <= flags_d;
    end
  end
  assign BURST_DONE  = done_q;
  assign PULSE_COUNT = pc_q;
  assign SIL_LEN     = sil_q;
  assign BURST_TOTAL = tot_q;
  assign ERR_FLAGS   = flags_q;
  assign ERR         = |flags_q;
endmodule

// File: tb/tb_sample_burst_monitor.sv
// tb_sample_burst_monitor: directed checks of burst decoding, error flags, reset and disable
module tb_sample_burst_monitor;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s = 1'b0, p = 1'b0, en = 1'b0, tr = 1'b0, clr = 1'b0;
  logic [11:0] div = 12'd0;
  logic [3:0]  cnt = 4'd0;
  logic [9:0]  p2 = 10'd0;
  logic        done, err;
  logic [4:0]  pc, flags;
  logic [12:0] sil;
  logic [15:0] tot;
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, last_done = 0, period = 0;
  sample_burst_monitor dut (
    .HF_CLK(clk), .NRST_sync(rst_n), .SAMPLE_CLK_in(s), .phase_in(p),
    .PHASE1DIV1_sync(div), .PHASE1COUNT_sync(cnt), .PHASE2COUNT_sync(p2),
    .ENSAMP_sync(en), .TEMP_RUN(tr), .CLR_ERR(clr),
    .BURST_DONE(done), .PULSE_COUNT(pc), .SIL_LEN(sil), .BURST_TOTAL(tot),
    .ERR_FLAGS(flags), .ERR(err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (done === 1'b1) begin
    period = cyc - last_done;
    last_done = cyc;
    done_cnt++;
  end
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic sv, input logic pv);
    s = sv;
    p = pv;
    @(posedge clk);
    #1;
  endtask
  task automatic seg(input logic sv, input logic pv, input int len);
    repeat (len) step(sv, pv);
  endtask
  task automatic pulses(input int d, input int n);
    for (int k = 0; k < n; k++) begin
      seg(1'b1, 1'b0, d);
      if (k < n - 1) seg(1'b0, 1'b0, d);
    end
  endtask
  task automatic burst(input int d, input int n, input int sl);
    pulses(d, n);
    if (sl == 0) seg(1'b0, 1'b0, d);
    else seg(1'b0, 1'b1, sl);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    en = 1'b0;
    tr = 1'b0;
    clr = 1'b0;
    s = 1'b0;
    p = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
  endtask
  task automatic cfg(input int d, input int n, input int sl);
    div = 12'(d);
    cnt = 4'(n);
    p2 = 10'(sl);
    en = 1'b1;
  endtask
  initial begin
    do_reset();
    chk("rst_done", done, 0);
    chk("rst_pc", pc, 0);
    chk("rst_sil", sil, 0);
    chk("rst_tot", tot, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    cfg(3, 4, 10);
    seg(1'b0, 1'b0, 3);
    repeat (5) burst(3, 4, 10);
    chk("norm_period", period, 31);
    chk("norm_dones", done_cnt, 5);
    chk("norm_pc", pc, 4);
    chk("norm_sil", sil, 10);
    chk("norm_flags", flags, 0);
    chk("norm_tot", tot, 5);
    do_reset();
    cfg(1, 0, 3);
    seg(1'b0, 1'b0, 3);
    repeat (3) burst(1, 16, 3);
    chk("p16_period", period, 34);
    chk("p16_pc", pc, 16);
    chk("p16_sil", sil, 3);
    chk("p16_flags", flags, 0);
    do_reset();
    cfg(2, 3, 0);
    seg(1'b0, 1'b0, 3);
    repeat (3) burst(2, 3, 0);
    chk("cont_period", period, 12);
    chk("cont_dones", done_cnt, 3);
    chk("cont_pc", pc, 3);
    chk("cont_flags", flags, 0);
    do_reset();
    cfg(3, 4, 10);
    seg(1'b0, 1'b0, 3);
    burst(3, 4, 10);
    seg(1'b1, 1'b0, 4);
    chk("hi_pre", flags, 0);
    step(1'b0, 1'b0);
    chk("hi_flags", flags, 1);
    chk("hi_err", err, 1);
    seg(1'b0, 1'b0, 2);
    seg(1'b1, 1'b0, 3);
    seg(1'b0, 1'b0, 3);
    pulses(3, 2);
    seg(1'b0, 1'b1, 9);
    step(1'b1, 1'b0);
    chk("sil_flags", flags, 9);
    chk("sil_len", sil, 9);
    clr = 1'b1;
    step(1'b1, 1'b0);
    clr = 1'b0;
    chk("clr_flags", flags, 0);
    chk("clr_err", err, 0);
    step(1'b1, 1'b0);
    seg(1'b0, 1'b0, 3);
    pulses(3, 3);
    seg(1'b0, 1'b1, 9);
    seg(1'b1, 1'b0, 4);
    chk("sil2_flags", flags, 8);
    clr = 1'b1;
    step(1'b0, 1'b0);
    clr = 1'b0;
    chk("clr_vs_hi", flags, 1);
    do_reset();
    cfg(3, 4, 10);
    seg(1'b0, 1'b0, 3);
    pulses(3, 3);
    step(1'b0, 1'b1);
    chk("cnt_done", done, 1);
    chk("cnt_flags", flags, 4);
    chk("cnt_pc", pc, 3);
    seg(1'b0, 1'b1, 9);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    chk("phase_flags", flags, 20);
    do_reset();
    cfg(3, 4, 10);
    seg(1'b0, 1'b0, 3);
    pulses(3, 4);
    seg(1'b0, 1'b1, 5);
    chk("mid_tot", tot, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_tot", tot, 0);
    chk("arst_pc", pc, 0);
    chk("arst_sil", sil, 0);
    chk("arst_done", done, 0);
    chk("arst_flags", flags, 0);
    s = 1'b0;
    p = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
    seg(1'b0, 1'b0, 3);
    repeat (2) burst(3, 4, 10);
    chk("post_rst_flags", flags, 0);
    chk("post_rst_tot", tot, 2);
    chk("post_rst_pc", pc, 4);
    pulses(3, 2);
    en = 1'b0;
    seg(1'b0, 1'b0, 3);
    tr = 1'b1;
    seg(1'b0, 1'b0, 3);
    repeat (2) burst(3, 4, 10);
    chk("dis_flags", flags, 0);
    chk("dis_tot", tot, 4);
    chk("dis_sil", sil, 10);
    div = 12'd0;
    for (int i = 0; i < 20; i++) step(i[0], ~i[0]);
    chk("pt_dones", done_cnt, 4);
    chk("pt_tot", tot, 4);
    chk("pt_flags", flags, 0);
    chk("pt_pc", pc, 4);
    chk("pt_sil", sil, 10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
